// File: rtl/stream_demux3.sv
// Steers each accepted word to one of three output channels (sel 11 discards it).
// Latency: a word accepted at one edge is presented no earlier than the following cycle.
// Backpressure: in_ready is low when two words are buffered; a stalled head blocks all later words.
module stream_demux3 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             empty
);

    // The state is the buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH+1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       head_sel;
    logic [WIDTH-1:0] head_data;
    logic             push;
    logic             pop;

    // Occupancy register; reset drops all valids immediately through the decode below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake decode, head presentation and occupancy next-state.
    always_comb begin
        state_nxt  = state;
        head_sel   = mem[rd_ptr][WIDTH+1:WIDTH];
        head_data  = mem[rd_ptr][WIDTH-1:0];
        in_ready   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        out2_valid = 1'b0;
        out_data   = '0;
        empty      = (state == EMPTY);

        // Only registered state gates acceptance, so there is no ready path from the outputs.
        in_ready = !rst && (state != FULL);
        push     = in_valid && in_ready;

        if (state != EMPTY) begin
            out_data   = head_data;
            out0_valid = (head_sel == 2'b00);
            out1_valid = (head_sel == 2'b01);
            out2_valid = (head_sel == 2'b10);
            // Discard words leave one per cycle without raising any channel valid.
            pop = (head_sel == 2'b11)
                || (out0_valid && out0_ready)
                || (out1_valid && out1_ready)
                || (out2_valid && out2_ready);
        end

        case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Entry storage and 1-bit pointers, which wrap naturally and keep arrival order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_sel, in_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Saturating count of discarded words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (pop && (head_sel == 2'b11) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_demux3.sv
// Randomized and directed bench for stream_demux3 with a queue-based scoreboard.
// Accepted words are captured from the input handshake; the output monitor pops and compares.
// Inputs change 2 time units after the rising edge; all sampling happens on the falling edge.
module tb_stream_demux3;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
    } item_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_sel = '0;
    logic             out0_valid, out1_valid, out2_valid;
    logic             out0_ready = 1'b0, out1_ready = 1'b0, out2_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] drop_cnt;
    logic             empty;

    int    n_checks = 0;
    int    n_errors = 0;
    item_t exp_q[$];
    item_t pend;
    bit    pend_v = 0;
    int    drop_exp = 0;
    int    delivered = 0;
    int    cyc = 0;
    bit    rnd_done = 0;

    stream_demux3 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_ready(out2_ready),
        .out_data(out_data), .drop_cnt(drop_cnt), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Input monitor: note a handshake on the falling edge, commit it at the rising edge.
    always @(negedge clk) begin
        pend_v = !rst && in_valid && in_ready;
        pend   = '{sel: in_sel, data: in_data};
    end

    always @(posedge clk) begin
        if (pend_v && !rst) exp_q.push_back(pend);
        pend_v = 0;
    end

    // Output monitor: the buffer is a 2-deep in-order queue; the head decides everything.
    always @(negedge clk) begin
        item_t      h;
        logic [2:0] expv;
        logic [2:0] rdy;
        if (!rst) begin
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("empty", empty, exp_q.size() == 0);
            chk("drop_cnt", drop_cnt, drop_exp);
            if (exp_q.size() == 0) begin
                chk("idle_valids", {out2_valid, out1_valid, out0_valid}, 3'b000);
                chk("idle_data", out_data, 0);
            end else begin
                h    = exp_q[0];
                expv = (h.sel == 2'b11) ? 3'b000 : (3'b001 << h.sel);
                rdy  = {out2_ready, out1_ready, out0_ready};
                chk("valids", {out2_valid, out1_valid, out0_valid}, expv);
                if (h.sel == 2'b11) begin
                    void'(exp_q.pop_front());
                    if (drop_exp < 255) drop_exp++;
                end else begin
                    chk("out_data", out_data, h.data);
                    if (rdy[h.sel]) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #2;
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        {out2_ready, out1_ready, out0_ready} = 3'b111;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (empty && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain", ok, 1);
        step();
        {out2_ready, out1_ready, out0_ready} = 3'b000;
    endtask

    initial begin
        int t0;
        int d0;
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int d0;
        // Reset values while rst is held
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_valids", {out2_valid, out1_valid, out0_valid}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        step();

        // Single word to channel 1, popped on its first presented cycle
        out1_ready = 1'b1;
        send(2'b01, 32'hAAAA0001);
        @(negedge clk);
        chk("t1_valid1", out1_valid, 1);
        chk("t1_data", out_data, 32'hAAAA0001);
        step();
        chk("t1_empty", empty, 1);
        out1_ready = 1'b0;

        // Fill to FULL with everything stalled; a third word is refused
        send(2'b00, 32'h11);
        send(2'b10, 32'h22);
        in_valid = 1'b1;
        in_sel   = 2'b00;
        in_data  = 32'h33;
        repeat (3) begin
            @(negedge clk);
            chk("t2_full_ready", in_ready, 0);
        end
        step();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        @(negedge clk);
        chk("t2_valid0", out0_valid, 1);
        chk("t2_data11", out_data, 32'h11);
        step();
        out0_ready = 1'b0;
        @(negedge clk);
        chk("t2_valid2", out2_valid, 1);
        chk("t2_data22", out_data, 32'h22);
        chk("t2_ready_back", in_ready, 1);
        step();
        drain();

        // Head-of-line blocking behind a stalled channel 0
        send(2'b00, 32'h5);
        send(2'b01, 32'h6);
        out1_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t3_valid0", out0_valid, 1);
            chk("t3_valid1", out1_valid, 0);
            chk("t3_data", out_data, 32'h5);
        end
        step();
        drain();

        // Discards, then saturation of the drop counter
        for (int i = 0; i < 3; i++) send(2'b11, i);
        drain();
        chk("t4_drop3", drop_cnt, 3);
        chk("t4_empty", empty, 1);
        for (int i = 0; i < 300; i++) send(2'b11, $urandom);
        drain();
        chk("t4_drop_sat", drop_cnt, 255);

        // Streaming through the ONE state, one word per cycle
        out1_ready = 1'b1;
        t0 = cyc;
        d0 = delivered;
        for (int i = 1; i <= 8; i++) send(2'b01, i);
        chk("t5_cycles", cyc - t0, 8);
        @(negedge clk);
        #1;
        chk("t5_delivered", delivered - d0, 8);
        step();
        drain();

        // Randomized traffic with random backpressure
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) send(2'($urandom_range(0, 3)), $urandom);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out0_ready = ($urandom_range(0, 9) < 6);
                    out1_ready = ($urandom_range(0, 9) < 6);
                    out2_ready = ($urandom_range(0, 9) < 6);
                end
            end
        join
        drain();

        // Asynchronous reset mid-cycle with two words buffered
        send(2'b00, 32'h77);
        send(2'b01, 32'h88);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_valids", {out2_valid, out1_valid, out0_valid}, 0);
        chk("t6_empty", empty, 1);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_in_ready", in_ready, 0);
        exp_q.delete();
        pend_v   = 0;
        drop_exp = 0;
        step();
        rst = 1'b0;
        #1;
        chk("t6_ready_after", in_ready, 1);
        step();
        out2_ready = 1'b1;
        d0 = delivered;
        send(2'b10, 32'hC0FFEE01);
        @(negedge clk);
        chk("t6_valid2", out2_valid, 1);
        chk("t6_data", out_data, 32'hC0FFEE01);
        step();
        chk("t6_delivered", delivered - d0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_demux3.md
Name: stream_demux3

Overview:
- 1-to-3 registered stream demultiplexer; the steering counterpart of the 3-input selectors in the datapath.
- Accepts one WIDTH-bit word plus a 2-bit destination select per valid/ready handshake.
- Buffers up to 2 words in arrival order.
- Presents the oldest word on the selected output channel, with per-channel valid/ready.

Parameters:
WIDTH, 32, data word width
CNT_W, 8, width of saturating drop counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream word present
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  upstream word
in_sel  input  2  destination: 00->out0, 01->out1, 10->out2, 11->discard
out0_valid  output  1  head word destined for channel 0
out0_ready  input  1  channel 0 consumer accepts
out1_valid  output  1  head word destined for channel 1
out1_ready  input  1  channel 1 consumer accepts
out2_valid  output  1  head word destined for channel 2
out2_ready  input  1  channel 2 consumer accepts
out_data  output  WIDTH  head word, shared by all three channels
drop_cnt  output  CNT_W  number of sel=11 words discarded, saturating
empty  output  1  buffer holds no words

Behaviour:
- Storage:
  - 2-entry FIFO of {in_sel, in_data}, with head/tail pointers and a count of 0..2.
  - States: EMPTY (count 0), ONE (count 1), FULL (count 2); the state is the count.
- Reset (rst=1, asynchronous):
  - count=0, pointers=0, drop_cnt=0.
  - All outN_valid=0, out_data=0, empty=1, in_ready=0 while rst is held.
- in_ready:
  - Equals (count<2) when not in reset.
  - It is a registered-state function only; it does not depend on outN_ready. There is no pass-through when FULL.
- Push: in_valid & in_ready at a rising edge writes the tail entry and advances the tail pointer (mod 2).
- Latency: a word accepted at edge k is visible on the outputs in the cycle after edge k, at the earliest. There is no combinational in->out path.
- Head presentation when count>0:
  - out_data = head data.
  - outN_valid = (head_sel==N), for N=0..2. At most one valid is high.
- Head presentation when count==0: all valids=0, out_data=0.
- Pop conditions:
  - Pop occurs at an edge when the selected channel has outN_valid & outN_ready.
  - Pop also occurs when head_sel==11 and count>0; this is automatic, one word per cycle, and no channel valid is raised.
- Discard: each sel=11 pop increments drop_cnt. drop_cnt saturates at 2^CNT_W-1 (255 by default) and does not wrap.
- Stability: while outN_valid=1 and outN_ready=0, out_data and outN_valid hold unchanged.
- Blocking:
  - A head word waiting on a stalled channel blocks all later words, even those for ready channels.
  - outN_ready on non-selected channels is ignored.
- Simultaneous push and pop:
  - In ONE, count stays 1 and both pointers advance.
  - In EMPTY, pop is impossible and only the push takes effect.
  - In FULL, the push is impossible (in_ready=0) and only the pop takes effect.
- Pointer wrap: pointers are 1 bit and wrap 1->0 naturally. FIFO order is preserved across wraps.
- empty = (count==0).
- Reset mid-operation: buffered words are lost, valids drop immediately (asynchronously), and drop_cnt clears.

Test Plan:
- Reset, then push 0xAAAA0001 with sel=01 while out1_ready=1 → next cycle out1_valid=1, out_data=0xAAAA0001, out0/out2_valid=0; it pops on that edge, then empty=1.
- All outN_ready=0; push 0x11 (sel 00), then 0x22 (sel 10), then offer 0x33 → in_ready=0 after the second push and 0x33 is not accepted. Raise out0_ready → 0x11 pops. Next, out2_valid=1 with 0x22, and in_ready=1 again.
- Head-of-line blocking: push 0x5 (sel 00) and 0x6 (sel 01); out0_ready=0, out1_ready=1 for 10 cycles → out0_valid holds, out_data=0x5 stable, and 0x6 is never presented.
- Discard: push 3 words with sel=11 → no valid asserted, drop_cnt=3, and empty=1 after 3 pops. Push 300 words with sel=11 → drop_cnt=255 (saturated).
- Streaming in ONE state: in_valid=1 and out1_ready=1 continuously, sel=01, data 1..8 → one word delivered per cycle in order 1..8, count never exceeds 1, pointers wrap 4 times.
- Assert rst asynchronously mid-cycle with count=2 → valids, count and drop_cnt go to 0 immediately; after release in_ready=1 and the first new word is delivered correctly.
